object_compositor: RTL and testbench

Pixel-side consumer of the per-object sprite controllers. It broadcasts the current VGA pixel coordinate to every object controller as `requested_x`/`requested_y` and collects each controller's registered `output_color` one cycle later. It resolves per-pixel priority between layers, treating the mask colour as transparent. It emits one composited 8-bit colour per pixel toward the VGA driver, and optionally accumulates per-frame player-vs-object overlap flags.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/layer_priority_select.sv | 25 ++
 rtl/object_compositor.sv | 102 ++++++++++
 tb/tb_object_compositor.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types and constants used by the object controllers and the compositor.
package vga_pkg;

  typedef logic [10:0] coord_t;
  typedef logic [7:0]  color_t;

  localparam color_t MASK_VALUE_DEFAULT = 8'h62;

  // Field indices into the per-object state record held by each controller.
  typedef enum logic [2:0] {
    IMG_ID = 3'd0,
    X      = 3'd1,
    Y      = 3'd2,
    WIDTH  = 3'd3,
    HEIGHT = 3'd4
  } obj_field_t;

  function automatic logic color_opaque(input color_t color, input color_t mask);
    return color != mask;
  endfunction

endpackage

// File: rtl/layer_priority_select.sv
// Combinational layer priority: the lowest-indexed non-mask colour wins.
module layer_priority_select
  import vga_pkg::*;
#(
  parameter int     NUM_LAYERS = 4,
  parameter color_t MASK_VALUE = MASK_VALUE_DEFAULT
) (
  input  logic [NUM_LAYERS*8-1:0] layer_color,
  output logic [7:0]              sel_color,
  output logic                    any_opaque
);

  // Walk from the lowest priority upwards so the last hit is the highest-priority layer.
  always_comb begin
    sel_color  = '0;
    any_opaque = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (color_opaque(layer_color[i*8 +: 8], MASK_VALUE)) begin
        sel_color  = layer_color[i*8 +: 8];
        any_opaque = 1'b1;
      end
    end
  end

endmodule

// File: rtl/object_compositor.sv
// Three-stage pixel compositor over NUM_LAYERS object controllers.
// Define OBJECT_COMPOSITOR_COLLISION_EN to build the per-frame player collision flags.
module object_compositor
  import vga_pkg::*;
#(
  parameter int     NUM_LAYERS = 4,
  parameter color_t MASK_VALUE = MASK_VALUE_DEFAULT,
  parameter color_t BG_COLOR   = 8'h00
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    frame_start,
  input  logic [10:0]             pixel_x,
  input  logic [10:0]             pixel_y,
  input  logic                    pixel_valid,
  output logic [10:0]             requested_x,
  output logic [10:0]             requested_y,
  input  logic [NUM_LAYERS*8-1:0] layer_color,
  output logic [7:0]              out_color,
  output logic                    out_valid,
  output logic [NUM_LAYERS-1:0]   collision_flags,
  output logic                    collision_any
);

  logic       v1;
  logic       v2;
  logic [7:0] sel_color;
  logic       any_opaque;

  // Coordinates keep flowing for invisible pixels so controllers see a continuous scan.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      requested_x <= '0;
      requested_y <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
    end else begin
      requested_x <= pixel_x;
      requested_y <= pixel_y;
      v1          <= pixel_valid;
      v2          <= v1;
    end
  end

  layer_priority_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .MASK_VALUE (MASK_VALUE)
  ) u_select (
    .layer_color (layer_color),
    .sel_color   (sel_color),
    .any_opaque  (any_opaque)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      out_color <= BG_COLOR;
      out_valid <= 1'b0;
    end else begin
      out_color <= (v2 && any_opaque) ? sel_color : BG_COLOR;
      out_valid <= v2;
    end
  end

`ifdef OBJECT_COMPOSITOR_COLLISION_EN
  logic [NUM_LAYERS-1:0] hit_acc;
  logic [NUM_LAYERS-1:0] hit_now;
  logic [NUM_LAYERS-1:0] hit_closing;

  // Bit 0 is the player itself and never reports a collision.
  always_comb begin
    hit_now = '0;
    for (int i = 1; i < NUM_LAYERS; i++) begin
      hit_now[i] = v2 && color_opaque(layer_color[7:0], MASK_VALUE)
                      && color_opaque(layer_color[i*8 +: 8], MASK_VALUE);
    end
  end

  assign hit_closing = hit_acc | hit_now;

  // Hits seen on the frame_start cycle itself belong to the frame that is closing.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      hit_acc         <= '0;
      collision_flags <= '0;
      collision_any   <= 1'b0;
    end else if (frame_start) begin
      hit_acc         <= '0;
      collision_flags <= hit_closing;
      collision_any   <= |hit_closing;
    end else begin
      hit_acc         <= hit_closing;
    end
  end
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign collision_flags    = '0;
  assign collision_any      = 1'b0;
`endif

endmodule

// File: tb/tb_object_compositor.sv
// Self-checking bench for object_compositor with fake table-driven object controllers.
module tb_object_compositor;

  localparam int         NUM_LAYERS = 4;
  localparam logic [7:0] MASK       = 8'h62;
  localparam logic [7:0] BG         = 8'h00;

  logic                    clk = 1'b0;
  logic                    resetN = 1'b0;
  logic                    frame_start = 1'b0;
  logic [10:0]             pixel_x = '0;
  logic [10:0]             pixel_y = '0;
  logic                    pixel_valid = 1'b0;
  logic [10:0]             requested_x;
  logic [10:0]             requested_y;
  logic [NUM_LAYERS*8-1:0] layer_color = '0;
  logic [7:0]              out_color;
  logic                    out_valid;
  logic [NUM_LAYERS-1:0]   collision_flags;
  logic                    collision_any;

  int checks = 0;
  int errors = 0;

  object_compositor #(
    .NUM_LAYERS (NUM_LAYERS),
    .MASK_VALUE (MASK),
    .BG_COLOR   (BG)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .frame_start     (frame_start),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .pixel_valid     (pixel_valid),
    .requested_x     (requested_x),
    .requested_y     (requested_y),
    .layer_color     (layer_color),
    .out_color       (out_color),
    .out_valid       (out_valid),
    .collision_flags (collision_flags),
    .collision_any   (collision_any)
  );

  always #5 clk = ~clk;

  // Each fake controller returns a table entry addressed by the requested coordinate, one cycle later.
  logic [7:0] layer_mem [NUM_LAYERS][16];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LAYERS; i++)
      layer_color[i*8 +: 8] <= layer_mem[i][requested_x[3:0] ^ requested_y[3:0]];
  end

  // Reference model state: input history per edge plus expected outputs.
  logic [10:0]           hx [8];
  logic [10:0]           hy [8];
  logic                  hv [8];
  logic                  hr [8];
  int                    ecount = 0;
  logic [10:0]           exp_req_x, exp_req_y;
  logic                  exp_valid;
  logic [7:0]            exp_color;
  logic [NUM_LAYERS-1:0] exp_acc = '0;
  logic [NUM_LAYERS-1:0] exp_flags = '0;
  logic                  exp_any = 1'b0;
`ifdef OBJECT_COMPOSITOR_COLLISION_EN
  localparam logic [NUM_LAYERS-1:0] HIT3 = 4'b1000;
`else
  localparam logic [NUM_LAYERS-1:0] HIT3 = 4'b0000;
`endif

  task automatic fill_mask();
    for (int i = 0; i < NUM_LAYERS; i++)
      for (int j = 0; j < 16; j++)
        layer_mem[i][j] = MASK;
  endtask

  // Drive one cycle of inputs, clock once, and update expectations from the pixel issued two edges earlier.
  task automatic step(input logic [10:0] px, input logic [10:0] py, input logic pv,
                      input logic fs, input logic rn);
    logic [7:0]            c [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] hit;
    int                    s, p, q;
    bit                    found;
    pixel_x = px; pixel_y = py; pixel_valid = pv; frame_start = fs; resetN = rn;
    @(posedge clk);
    #1;
    ecount++;
    s = ecount % 8;
    q = (ecount + 7) % 8;
    p = (ecount + 6) % 8;
    hx[s] = px; hy[s] = py; hv[s] = pv; hr[s] = rn;
    exp_req_x = rn ? px : 11'd0;
    exp_req_y = rn ? py : 11'd0;
    exp_valid = (ecount >= 3) && hv[p] && hr[p] && hr[q] && hr[s];
    for (int i = 0; i < NUM_LAYERS; i++)
      c[i] = layer_mem[i][hx[p][3:0] ^ hy[p][3:0]];
    exp_color = BG;
    found = 0;
    hit = '0;
    if (exp_valid) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (!found && c[i] != MASK) begin
          exp_color = c[i];
          found = 1;
        end
      end
      if (c[0] != MASK)
        for (int i = 1; i < NUM_LAYERS; i++)
          hit[i] = (c[i] != MASK);
    end
`ifdef OBJECT_COMPOSITOR_COLLISION_EN
    if (!rn) begin
      exp_acc = '0; exp_flags = '0;
    end else if (fs) begin
      exp_flags = exp_acc | hit; exp_acc = '0;
    end else begin
      exp_acc = exp_acc | hit;
    end
`endif
    exp_any = |exp_flags;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(11'd0, 11'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    fill_mask();
    for (int k = 0; k < 3; k++) step(11'd77, 11'd33, 1'b1, 1'b1, 1'b0);
    checks++;
    if (requested_x !== 11'd0 || requested_y !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_requested got %0d,%0d expected 0,0", requested_x, requested_y);
    end
    checks++;
    if (out_valid !== 1'b0 || out_color !== BG) begin
      errors++;
      $display("[TB] FAIL reset_out got valid=%0b color=%h expected valid=0 color=%h", out_valid, out_color, BG);
    end
    checks++;
    if (collision_flags !== '0 || collision_any !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_collision got flags=%b any=%b expected 0000 0", collision_flags, collision_any);
    end
    idle(3);
  endtask

  task automatic test_priority();
    fill_mask();
    layer_mem[2][1] = 8'h1C;
    layer_mem[0][2] = 8'hE0;
    layer_mem[1][2] = 8'h03;
    step(11'd1, 11'd0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_edge1 got valid=%b expected 0", out_valid);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_edge2 got valid=%b expected 0", out_valid);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_color !== 8'h1C) begin
      errors++;
      $display("[TB] FAIL only_layer2 got valid=%b color=%h expected 1 1c", out_valid, out_color);
    end
    step(11'd2, 11'd0, 1'b1, 1'b0, 1'b1);
    step(11'd3, 11'd0, 1'b1, 1'b0, 1'b1);
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_color !== 8'hE0) begin
      errors++;
      $display("[TB] FAIL player_wins got valid=%b color=%h expected 1 e0", out_valid, out_color);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_color !== BG) begin
      errors++;
      $display("[TB] FAIL all_mask got valid=%b color=%h expected 1 %h", out_valid, out_color, BG);
    end
    idle(3);
  endtask

  task automatic test_invisible();
    fill_mask();
    layer_mem[0][4] = 8'hFF;
    step(11'd4, 11'h010, 1'b0, 1'b0, 1'b1);
    checks++;
    if (requested_x !== 11'd4 || requested_y !== 11'h010) begin
      errors++;
      $display("[TB] FAIL invisible_requested got %h,%h expected 004,010", requested_x, requested_y);
    end
    idle(2);
    checks++;
    if (out_valid !== 1'b0 || out_color !== BG) begin
      errors++;
      $display("[TB] FAIL invisible_out got valid=%b color=%h expected 0 %h", out_valid, out_color, BG);
    end
    idle(3);
  endtask

  task automatic test_collision();
    fill_mask();
    layer_mem[0][5] = 8'hE0;
    layer_mem[3][5] = 8'h1C;
    step(11'd0, 11'd0, 1'b0, 1'b1, 1'b1);
    step(11'd5, 11'd0, 1'b1, 1'b0, 1'b1);
    idle(3);
    step(11'd0, 11'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (collision_flags !== HIT3 || collision_any !== (|HIT3)) begin
      errors++;
      $display("[TB] FAIL frame_hit got flags=%b any=%b expected %b %b", collision_flags, collision_any, HIT3, |HIT3);
    end
    idle(2);
    checks++;
    if (collision_flags !== HIT3) begin
      errors++;
      $display("[TB] FAIL flags_hold got %b expected %b", collision_flags, HIT3);
    end
    step(11'd0, 11'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (collision_flags !== '0 || collision_any !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_clear got flags=%b any=%b expected 0000 0", collision_flags, collision_any);
    end
    step(11'd5, 11'd0, 1'b1, 1'b0, 1'b1);
    idle(1);
    step(11'd0, 11'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (collision_flags !== HIT3 || collision_any !== (|HIT3)) begin
      errors++;
      $display("[TB] FAIL same_cycle_hit got flags=%b any=%b expected %b %b", collision_flags, collision_any, HIT3, |HIT3);
    end
    step(11'd0, 11'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (collision_flags !== '0 || collision_any !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_cycle_not_carried got flags=%b any=%b expected 0000 0", collision_flags, collision_any);
    end
    idle(3);
  endtask

  task automatic test_reset_midline();
    fill_mask();
    layer_mem[0][5] = 8'hE0;
    layer_mem[3][5] = 8'h1C;
    for (int k = 0; k < 3; k++) step(11'd5, 11'd0, 1'b1, 1'b0, 1'b1);
    step(11'd5, 11'd0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (collision_flags !== HIT3 || out_valid !== 1'b1 || out_color !== 8'hE0) begin
      errors++;
      $display("[TB] FAIL pre_reset got flags=%b valid=%b color=%h expected %b 1 e0", collision_flags, out_valid, out_color, HIT3);
    end
    step(11'd5, 11'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || requested_x !== 11'd0 || requested_y !== 11'd0 || collision_flags !== '0) begin
      errors++;
      $display("[TB] FAIL midline_reset got valid=%b req=%0d,%0d flags=%b expected 0 0,0 0000", out_valid, requested_x, requested_y, collision_flags);
    end
    for (int k = 1; k <= 3; k++) begin
      step(11'd5, 11'd0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (out_valid !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL post_reset_edge%0d got valid=%b expected %b", k, out_valid, k == 3);
      end
    end
    checks++;
    if (out_color !== 8'hE0) begin
      errors++;
      $display("[TB] FAIL post_reset_color got %h expected e0", out_color);
    end
    idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < NUM_LAYERS; i++)
      for (int j = 0; j < 16; j++)
        layer_mem[i][j] = ($urandom_range(0, 1) == 0) ? MASK : 8'($urandom_range(0, 255));
    for (int k = 0; k < 600; k++) begin
      step(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
           ($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 100) != 0);
      checks++;
      if (requested_x !== exp_req_x || requested_y !== exp_req_y) begin
        errors++;
        $display("[TB] FAIL rand_requested cycle %0d got %h,%h expected %h,%h", k, requested_x, requested_y, exp_req_x, exp_req_y);
      end
      checks++;
      if (out_valid !== exp_valid || out_color !== exp_color) begin
        errors++;
        $display("[TB] FAIL rand_pixel cycle %0d got valid=%b color=%h expected %b %h", k, out_valid, out_color, exp_valid, exp_color);
      end
      checks++;
      if (collision_flags !== exp_flags || collision_any !== exp_any) begin
        errors++;
        $display("[TB] FAIL rand_collision cycle %0d got flags=%b any=%b expected %b %b", k, collision_flags, collision_any, exp_flags, exp_any);
      end
    end
    idle(3);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      hx[i] = '0; hy[i] = '0; hv[i] = 1'b0; hr[i] = 1'b0;
    end
    fill_mask();
    test_reset();
    test_priority();
    test_invisible();
    test_collision();
    test_reset_midline();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
